// File: rtl/imm12_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm12_encoder_pkg
//
// Shared widths for the 12-bit shifter-operand encoder and its matching
// decoder (val2_generator). The rotate/immediate split is common to both
// sides so that decode(encode(x)) == x holds by construction.
//
// Contents:
//   WORD_WIDTH_DEF             default data word width (32)
//   SHIFTER_OPERAND_WIDTH_DEF  default encoded operand width (12)
//   ROT_FIELD_WIDTH            width of the even-rotate field (4)
//   IMM8_WIDTH                 width of the rotated immediate (8)
// -----------------------------------------------------------------------------
package imm12_encoder_pkg;

    localparam int WORD_WIDTH_DEF            = 32;
    localparam int SHIFTER_OPERAND_WIDTH_DEF = 12;
    localparam int ROT_FIELD_WIDTH           = 4;
    localparam int IMM8_WIDTH                = 8;

endpackage

// File: rtl/imm12_encoder.sv
// -----------------------------------------------------------------------------
// imm12_encoder
//
// Iterative encoder producing the 12-bit shifter operand that val2_generator
// expands back into a 32-bit Val2.
//
//   is_for_memory = 0 : plain mode, operand is value[11:0] zero-extended,
//                       resolved in a single step.
//   is_for_memory = 1 : rotated mode, searches rot = 0..15 one per cycle for
//                       the smallest rot with rol(value, 2*rot) < 256 and
//                       emits {rot, imm8}.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_valid       request present
//   in_ready       block can accept a request (IDLE only)
//   value          constant to encode (captured on accept)
//   is_for_memory  mode select (captured on accept)
//   out_valid      result available (DONE)
//   out_ready      consumer takes the result
//   shift_operand  encoded field, {rot, imm8} in rotated mode
//   encodable      1 if shift_operand reproduces value
// -----------------------------------------------------------------------------
module imm12_encoder
    import imm12_encoder_pkg::*;
#(
    parameter int WORD_WIDTH            = WORD_WIDTH_DEF,
    parameter int SHIFTER_OPERAND_WIDTH = SHIFTER_OPERAND_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            value,
    input  logic                             is_for_memory,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand,
    output logic                             encodable
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [ROT_FIELD_WIDTH-1:0]         rot_q, rot_d;
    logic [WORD_WIDTH-1:0]              work_q, work_d;
    logic [SHIFTER_OPERAND_WIDTH-1:0]   operand_q, operand_d;
    logic                               encodable_q, encodable_d;

    // Circular left shift by one even-rotate step (2 bits).
    function automatic logic [WORD_WIDTH-1:0] rol2(input logic [WORD_WIDTH-1:0] w);
        return {w[WORD_WIDTH-3:0], w[WORD_WIDTH-1:WORD_WIDTH-2]};
    endfunction

    // The current rotation fits when only the low immediate bits are set.
    function automatic logic fits_imm8(input logic [WORD_WIDTH-1:0] w);
        return (w[WORD_WIDTH-1:IMM8_WIDTH] == '0);
    endfunction

    // Plain mode only accepts values that zero-extend from the operand width.
    function automatic logic fits_plain(input logic [WORD_WIDTH-1:0] w);
        return (w[WORD_WIDTH-1:SHIFTER_OPERAND_WIDTH] == '0);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rot_d       = rot_q;
        work_d      = work_q;
        operand_d   = operand_q;
        encodable_d = encodable_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_for_memory) begin
                        state_d = ST_SEARCH;
                        rot_d   = '0;
                        work_d  = value;
                    end else begin
                        state_d     = ST_DONE;
                        encodable_d = fits_plain(value);
                        operand_d   = fits_plain(value) ? value[SHIFTER_OPERAND_WIDTH-1:0] : '0;
                    end
                end
            end

            ST_SEARCH: begin
                // Testing rot in ascending order guarantees the smallest
                // valid rotation wins when several would work.
                if (fits_imm8(work_q)) begin
                    state_d     = ST_DONE;
                    operand_d   = {rot_q, work_q[IMM8_WIDTH-1:0]};
                    encodable_d = 1'b1;
                end else if (rot_q == '1) begin
                    state_d     = ST_DONE;
                    operand_d   = '0;
                    encodable_d = 1'b0;
                end else begin
                    // Invariant: work == rol(value, 2*rot).
                    rot_d  = rot_q + ROT_FIELD_WIDTH'(1);
                    work_d = rol2(work_q);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rot_q       <= '0;
            work_q      <= '0;
            operand_q   <= '0;
            encodable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rot_q       <= rot_d;
            work_q      <= work_d;
            operand_q   <= operand_d;
            encodable_q <= encodable_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign shift_operand = operand_q;
    assign encodable     = encodable_q;

endmodule
